mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single shared memory port of the pipelined CPU. Accepts word fetch requests from the IF stage and word/byte load/store requests from the MEM stage, using the same 2-bit MemRead/MemWrite encoding the decode stage emits (01 word, 10 byte). Runs one multi-cycle memory transaction at a time and pulses a per-requester ready. Drives the pipeline stall line.

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter/sequencer for the IF (fetch) and MEM (load/store) stages.
// Optional ack watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT_CYC    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic [1:0]        dm_read,
   input  logic [1:0]        dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              dm_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              pipe_stall,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [1:0]          mem_size_q, mem_size_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                if_ready_q, if_ready_d;
   logic                dm_ready_q, dm_ready_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         dm_rdata_q, dm_rdata_d;
   logic                err_q, err_d;
   logic [7:0]          burst_cnt_q, burst_cnt_d;

`ifdef MEM_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0]     wdog_q, wdog_d;
`endif

   logic       rd_any, wr_any, code_bad, dm_valid, dm_proto_err;
   logic [1:0] dm_code;
   logic       if_pend, dm_pend, burst_full, grant_if, grant_dm;
   logic [7:0] ld_byte;

   assign rd_any       = |dm_read;
   assign wr_any       = |dm_write;
   assign code_bad     = (dm_read == 2'b11) | (dm_write == 2'b11);
   assign dm_proto_err = code_bad | (rd_any & wr_any);
   assign dm_valid     = (rd_any ^ wr_any) & ~code_bad;
   assign dm_code      = rd_any ? dm_read : dm_write;

   // A retiring requester is masked, but a still-present data request keeps
   // blocking the fetch so that a held MEM stream is what burst_cnt limits.
   assign if_pend    = if_req & ~if_ready_q;
   assign dm_pend    = dm_valid & ~dm_ready_q;
   assign burst_full = (burst_cnt_q == 8'(MAX_DATA_BURST));
   assign grant_dm   = dm_pend & ~(burst_full & if_pend);
   assign grant_if   = if_pend & (burst_full | ~dm_valid);

   always_comb begin
      case (mem_addr_q[1:0])
         2'b00:   ld_byte = mem_rdata[31:24];
         2'b01:   ld_byte = mem_rdata[23:16];
         2'b10:   ld_byte = mem_rdata[15:8];
         default: ld_byte = mem_rdata[7:0];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      err_d       = err_q | dm_proto_err;
      burst_cnt_d = if_req ? burst_cnt_q : 8'd0;
`ifdef MEM_TIMEOUT_EN
      wdog_d      = '0;
`endif
      case (state_q)
         IDLE: begin
            if (grant_dm) begin
               state_d     = DM_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = wr_any;
               mem_size_d  = dm_code;
               mem_addr_d  = dm_addr;
               mem_wdata_d = (wr_any && dm_write == 2'b10) ? {4{dm_wdata[7:0]}} : dm_wdata;
               if (if_req) begin
                  burst_cnt_d = burst_cnt_q + 8'd1;
               end
            end else if (grant_if) begin
               state_d     = IF_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_size_d  = 2'b01;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               burst_cnt_d = 8'd0;
            end
         end
         IF_BUSY, DM_BUSY: begin
`ifdef MEM_TIMEOUT_EN
            wdog_d = wdog_q + WD_W'(1);
`endif
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == IF_BUSY) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  dm_ready_d = 1'b1;
                  if (!mem_we_q) begin
                     dm_rdata_d = (mem_size_q == 2'b10) ? {{24{ld_byte[7]}}, ld_byte} : mem_rdata;
                  end
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               if (state_q == IF_BUSY) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = 32'hDEADBEEF;
               end else begin
                  dm_ready_d = 1'b1;
                  dm_rdata_d = 32'hDEADBEEF;
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_size_q  <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         err_q       <= 1'b0;
         burst_cnt_q <= 8'd0;
`ifdef MEM_TIMEOUT_EN
         wdog_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         err_q       <= err_d;
         burst_cnt_q <= burst_cnt_d;
`ifdef MEM_TIMEOUT_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_size   = mem_size_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign if_ready   = if_ready_q;
   assign dm_ready   = dm_ready_q;
   assign if_rdata   = if_rdata_q;
   assign dm_rdata   = dm_rdata_q;
   assign err        = err_q;
   assign pipe_stall = (if_req & ~if_ready_q) | (dm_valid & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard testbench for mem_port_arbiter with a behavioural memory responder.
module tb_mem_port_arbiter;

   localparam int ADDR_W    = 32;
   localparam int MAX_BURST = 4;
   localparam int TMO       = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic [1:0]  dm_read, dm_write;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ready;
   logic        mem_req, mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        pipe_stall, err;

   typedef struct packed {logic is_if; logic [31:0] data;} exp_t;
   typedef struct packed {logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;} grant_t;

   exp_t   exp_q[$];
   grant_t grant_q[$];

   int check_cnt = 0;
   int pass_cnt  = 0;
   logic ack_en;
   int   ack_wait;
   int   busy_seen;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_BURST(MAX_BURST), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pipe_stall(pipe_stall), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      case (w)
         32'h40:  return 32'h2008000A;
         32'h100: return 32'h12345680;
         default: return {~w[15:0], w[15:0]};
      endcase
   endfunction

   // Memory responder: acks after ack_wait busy cycles and logs each completed transaction
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD0BAD;
      busy_seen = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = 32'h0BAD0BAD;
         if (mem_req && ack_en) begin
            if (busy_seen >= ack_wait) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_model(mem_addr);
               busy_seen = 0;
               grant_q.push_back(grant_t'{mem_we, mem_size, mem_addr, mem_wdata});
            end else begin
               busy_seen++;
            end
         end else begin
            busy_seen = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      grant_q.delete();
   endtask

   task automatic test_reset;
      @(negedge clk);
      check_cnt++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req: got %0b want 0", mem_req); else pass_cnt++;
      check_cnt++; if (if_ready !== 1'b0) $display("[TB] FAIL reset_if_ready: got %0b want 0", if_ready); else pass_cnt++;
      check_cnt++; if (dm_ready !== 1'b0) $display("[TB] FAIL reset_dm_ready: got %0b want 0", dm_ready); else pass_cnt++;
      check_cnt++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %0b want 0", err); else pass_cnt++;
      check_cnt++; if (if_rdata !== 32'h0) $display("[TB] FAIL reset_if_rdata: got %h want 0", if_rdata); else pass_cnt++;
      check_cnt++; if (dm_rdata !== 32'h0) $display("[TB] FAIL reset_dm_rdata: got %h want 0", dm_rdata); else pass_cnt++;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_fetch;
      int n = 0;
      bit seen = 0;
      bit stall_ok = 1;
      exp_t e;
      grant_t g;
      ack_wait = 2;
      tick();
      if_addr = 32'h40;
      if_req  = 1'b1;
      exp_q.push_back(exp_t'{1'b1, 32'h2008000A});
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         if (if_ready) seen = 1;
         else if (pipe_stall !== 1'b1) stall_ok = 0;
      end
      check_cnt++; if (!seen) $display("[TB] FAIL fetch_ready: no if_ready within %0d cycles", n); else pass_cnt++;
      check_cnt++; if (!stall_ok) $display("[TB] FAIL fetch_stall: got stall low before ready, want high"); else pass_cnt++;
      check_cnt++; if (pipe_stall !== 1'b0) $display("[TB] FAIL fetch_stall_release: got %0b want 0", pipe_stall); else pass_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'{1'b0, 32'hFFFF_FFFF};
      check_cnt++; if (if_rdata !== e.data) $display("[TB] FAIL fetch_rdata: got %h want %h", if_rdata, e.data); else pass_cnt++;
      g = (grant_q.size() > 0) ? grant_q.pop_front() : grant_t'('1);
      check_cnt++;
      if ({g.we, g.size, g.addr} !== {1'b0, 2'b01, 32'h40})
         $display("[TB] FAIL fetch_grant: got we=%0b size=%b addr=%h want we=0 size=01 addr=40", g.we, g.size, g.addr);
      else pass_cnt++;
      tick();
      if_req = 1'b0;
      @(negedge clk);
      check_cnt++; if (if_ready !== 1'b0) $display("[TB] FAIL fetch_pulse_width: got %0b want 0", if_ready); else pass_cnt++;
      check_cnt++; if (if_rdata !== 32'h2008000A) $display("[TB] FAIL fetch_rdata_hold: got %h want 2008000a", if_rdata); else pass_cnt++;
   endtask

   typedef struct packed {
      logic [1:0] rd; logic [1:0] wr; logic [31:0] addr; logic [31:0] wdata;
      int wait_c; logic [31:0] exp_data; logic [1:0] size; logic [31:0] exp_wdata;
   } acc_t;

   task automatic test_data_access;
      acc_t tbl[6];
      exp_t e;
      grant_t g;
      tbl[0] = '{2'b01, 2'b00, 32'h108, 32'h0,        0, 32'hFEF70108, 2'b01, 32'h0};
      tbl[1] = '{2'b10, 2'b00, 32'h103, 32'h0,        1, 32'hFFFFFF80, 2'b10, 32'h0};
      tbl[2] = '{2'b10, 2'b00, 32'h100, 32'h0,        1, 32'h00000012, 2'b10, 32'h0};
      tbl[3] = '{2'b10, 2'b00, 32'h102, 32'h0,        0, 32'h00000056, 2'b10, 32'h0};
      tbl[4] = '{2'b00, 2'b10, 32'h021, 32'h000000C3, 1, 32'h0,        2'b10, 32'hC3C3C3C3};
      tbl[5] = '{2'b00, 2'b01, 32'h024, 32'hCAFEF00D, 2, 32'h0,        2'b01, 32'hCAFEF00D};
      for (int i = 0; i < 6; i++) begin
         int n = 0;
         bit seen = 0;
         ack_wait = tbl[i].wait_c;
         tick();
         dm_read  = tbl[i].rd;
         dm_write = tbl[i].wr;
         dm_addr  = tbl[i].addr;
         dm_wdata = tbl[i].wdata;
         exp_q.push_back(exp_t'{1'b0, tbl[i].exp_data});
         while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (dm_ready) seen = 1;
         end
         check_cnt++; if (!seen) $display("[TB] FAIL data_ready[%0d]: no dm_ready within %0d cycles", i, n); else pass_cnt++;
         if (i == 0) begin
            check_cnt++; if (n != 3) $display("[TB] FAIL min_latency: got %0d cycles want 3", n); else pass_cnt++;
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'{1'b1, 32'hFFFF_FFFF};
         if (tbl[i].rd != 2'b00) begin
            check_cnt++; if (dm_rdata !== e.data) $display("[TB] FAIL load_rdata[%0d]: got %h want %h", i, dm_rdata, e.data); else pass_cnt++;
         end
         g = (grant_q.size() > 0) ? grant_q.pop_front() : grant_t'('1);
         check_cnt++;
         if ({g.we, g.size, g.addr} !== {(tbl[i].wr != 2'b00), tbl[i].size, tbl[i].addr})
            $display("[TB] FAIL data_grant[%0d]: got we=%0b size=%b addr=%h want we=%0b size=%b addr=%h",
                     i, g.we, g.size, g.addr, (tbl[i].wr != 2'b00), tbl[i].size, tbl[i].addr);
         else pass_cnt++;
         if (tbl[i].wr != 2'b00) begin
            check_cnt++; if (g.wdata !== tbl[i].exp_wdata) $display("[TB] FAIL store_wdata[%0d]: got %h want %h", i, g.wdata, tbl[i].exp_wdata); else pass_cnt++;
         end
         tick();
         dm_read  = 2'b00;
         dm_write = 2'b00;
      end
   endtask

   task automatic test_priority;
      int n = 0;
      bit got_if = 0, got_dm = 0, overlap = 0;
      exp_t e;
      grant_t g;
      logic [31:0] obs;
      ack_wait = 1;
      tick();
      if_req  = 1'b1;
      if_addr = 32'h200;
      dm_read = 2'b01;
      dm_addr = 32'h300;
      exp_q.push_back(exp_t'{1'b0, mem_model(32'h300)});
      exp_q.push_back(exp_t'{1'b1, mem_model(32'h200)});
      while (!(got_if && got_dm) && n < 60) begin
         @(negedge clk);
         n++;
         if (if_ready && dm_ready) overlap = 1;
         if (if_ready || dm_ready) begin
            e   = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'{1'b0, 32'hFFFF_FFFF};
            obs = if_ready ? if_rdata : dm_rdata;
            check_cnt++;
            if (e.is_if !== if_ready || obs !== e.data)
               $display("[TB] FAIL prio_order: got is_if=%0b data=%h want is_if=%0b data=%h", if_ready, obs, e.is_if, e.data);
            else pass_cnt++;
            if (dm_ready) got_dm = 1;
            if (if_ready) got_if = 1;
            tick();
            if (got_dm) dm_read = 2'b00;
            if (got_if) if_req = 1'b0;
         end
      end
      check_cnt++; if (!(got_if && got_dm)) $display("[TB] FAIL prio_done: got if=%0b dm=%0b want both", got_if, got_dm); else pass_cnt++;
      check_cnt++; if (overlap) $display("[TB] FAIL prio_overlap: got overlapping readies want none"); else pass_cnt++;
      g = (grant_q.size() > 0) ? grant_q.pop_front() : grant_t'('1);
      check_cnt++; if (g.addr !== 32'h300) $display("[TB] FAIL prio_first_grant: got %h want 300", g.addr); else pass_cnt++;
      g = (grant_q.size() > 0) ? grant_q.pop_front() : grant_t'('1);
      check_cnt++; if (g.addr !== 32'h200) $display("[TB] FAIL prio_second_grant: got %h want 200", g.addr); else pass_cnt++;
      if_req  = 1'b0;
      dm_read = 2'b00;
   endtask

   task automatic test_starvation;
      logic [31:0] order[6];
      int n = 0, readies = 0, d_issued = 1;
      exp_t e;
      grant_t g;
      logic [31:0] obs;
      order = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h80, 32'h410};
      for (int i = 0; i < 6; i++)
         exp_q.push_back(exp_t'{(order[i] == 32'h80), mem_model(order[i])});
      ack_wait = 0;
      tick();
      if_req  = 1'b1;
      if_addr = 32'h80;
      dm_read = 2'b01;
      dm_addr = 32'h400;
      while (readies < 6 && n < 200) begin
         @(negedge clk);
         n++;
         if (if_ready || dm_ready) begin
            readies++;
            e   = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'{1'b0, 32'hFFFF_FFFF};
            obs = if_ready ? if_rdata : dm_rdata;
            check_cnt++;
            if (e.is_if !== if_ready || obs !== e.data)
               $display("[TB] FAIL starve_ready[%0d]: got is_if=%0b data=%h want is_if=%0b data=%h", readies, if_ready, obs, e.is_if, e.data);
            else pass_cnt++;
            if (if_ready) begin
               check_cnt++;
               if (dut.burst_cnt_q !== 8'd0) $display("[TB] FAIL starve_burst_clear: got %0d want 0", dut.burst_cnt_q); else pass_cnt++;
               tick();
               if_req = 1'b0;
            end else begin
               tick();
               if (d_issued < 5) begin
                  dm_addr = 32'h400 + 32'(4 * d_issued);
                  d_issued++;
               end else begin
                  dm_read = 2'b00;
               end
            end
         end
      end
      check_cnt++; if (readies != 6) $display("[TB] FAIL starve_done: got %0d readies want 6", readies); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         g = (grant_q.size() > 0) ? grant_q.pop_front() : grant_t'('1);
         check_cnt++;
         if (g.addr !== order[i]) $display("[TB] FAIL starve_grant[%0d]: got %h want %h", i, g.addr, order[i]); else pass_cnt++;
      end
      if_req  = 1'b0;
      dm_read = 2'b00;
   endtask

   task automatic test_protocol_error;
      bit req_seen = 0, stall_seen = 0;
      tick();
      dm_read  = 2'b01;
      dm_write = 2'b01;
      dm_addr  = 32'h600;
      repeat (5) begin
         @(negedge clk);
         if (mem_req) req_seen = 1;
         if (pipe_stall) stall_seen = 1;
      end
      check_cnt++; if (req_seen) $display("[TB] FAIL proto_no_req: got mem_req=1 want 0"); else pass_cnt++;
      check_cnt++; if (stall_seen) $display("[TB] FAIL proto_no_stall: got pipe_stall=1 want 0"); else pass_cnt++;
      check_cnt++; if (err !== 1'b1) $display("[TB] FAIL proto_err: got %0b want 1", err); else pass_cnt++;
      tick();
      dm_read  = 2'b00;
      dm_write = 2'b00;
      repeat (3) @(negedge clk);
      check_cnt++; if (err !== 1'b1) $display("[TB] FAIL proto_err_sticky: got %0b want 1", err); else pass_cnt++;
   endtask

   task automatic test_reset_mid_busy;
      int n = 0;
      bit req_seen = 0;
      ack_en = 1'b0;
      tick();
      dm_read = 2'b01;
      dm_addr = 32'h700;
      while (!mem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_cnt++; if (mem_req !== 1'b1) $display("[TB] FAIL rst_busy_start: got mem_req=%0b want 1", mem_req); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      check_cnt++; if (mem_req !== 1'b0) $display("[TB] FAIL rst_busy_req: got %0b want 0", mem_req); else pass_cnt++;
      check_cnt++; if ({if_ready, dm_ready} !== 2'b00) $display("[TB] FAIL rst_busy_ready: got %b want 00", {if_ready, dm_ready}); else pass_cnt++;
      check_cnt++; if (err !== 1'b0) $display("[TB] FAIL rst_busy_err: got %0b want 0", err); else pass_cnt++;
      dm_read = 2'b00;
      ack_en  = 1'b1;
      tick();
      rst_n = 1'b1;
      grant_q.delete();
      // Reserved code 11 alone must also flag an error without a request
      tick();
      dm_read = 2'b11;
      repeat (2) begin
         @(negedge clk);
         if (mem_req) req_seen = 1;
      end
      tick();
      dm_read = 2'b00;
      @(negedge clk);
      check_cnt++; if (req_seen) $display("[TB] FAIL code11_no_req: got mem_req=1 want 0"); else pass_cnt++;
      check_cnt++; if (err !== 1'b1) $display("[TB] FAIL code11_err: got %0b want 1", err); else pass_cnt++;
      do_reset();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout;
      int n = 0, req_cycles = 0;
      bit seen = 0;
      exp_t e;
      ack_en = 1'b0;
      tick();
      dm_read = 2'b01;
      dm_addr = 32'h500;
      exp_q.push_back(exp_t'{1'b0, 32'hDEADBEEF});
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (mem_req) req_cycles++;
         if (dm_ready) seen = 1;
      end
      check_cnt++; if (!seen) $display("[TB] FAIL tmo_ready: no dm_ready within %0d cycles", n); else pass_cnt++;
      check_cnt++; if (req_cycles != TMO) $display("[TB] FAIL tmo_busy_cycles: got %0d want %0d", req_cycles, TMO); else pass_cnt++;
      check_cnt++; if (mem_req !== 1'b0) $display("[TB] FAIL tmo_req_drop: got %0b want 0", mem_req); else pass_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'{1'b0, 32'h0};
      check_cnt++; if (dm_rdata !== e.data) $display("[TB] FAIL tmo_rdata: got %h want %h", dm_rdata, e.data); else pass_cnt++;
      check_cnt++; if (err !== 1'b1) $display("[TB] FAIL tmo_err: got %0b want 1", err); else pass_cnt++;
      tick();
      dm_read = 2'b00;
      ack_en  = 1'b1;
      do_reset();
   endtask
`endif

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      rst_n    = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_read  = 2'b00;
      dm_write = 2'b00;
      dm_addr  = '0;
      dm_wdata = '0;
      ack_en   = 1'b1;
      ack_wait = 0;
      #1 rst_n = 1'b0;
      $display("[TB] starting mem_port_arbiter bench");
      test_reset();
      test_fetch();
      test_data_access();
      test_priority();
      test_starvation();
      test_protocol_error();
      test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
